// File: rtl/ysyx_22041752_mul_r4_pkg.sv
// Shared encodings for the radix-4 Booth multiplier: mul_op codes and FSM states.
package ysyx_22041752_mul_r4_pkg;

  localparam int RF_DATA_WD = 64;

  localparam logic [1:0] MUL_OP_LO  = 2'd0;
  localparam logic [1:0] MUL_OP_H   = 2'd1;
  localparam logic [1:0] MUL_OP_HSU = 2'd2;
  localparam logic [1:0] MUL_OP_HU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/ysyx_22041752_booth_sel.sv
// Radix-4 Booth partial-product selector, purely combinational.
// Returns the magnitude (0, M or 2M); the caller applies negation via neg.
module ysyx_22041752_booth_sel #(
  parameter int XLEN = 64
) (
  input  logic [2:0]      sel,
  input  logic [XLEN+1:0] m,
  output logic [XLEN+1:0] addend,
  output logic            neg
);

  always_comb begin
    addend = '0;
    neg    = 1'b0;
    case (sel)
      3'b001, 3'b010: addend = m;
      3'b011:         addend = {m[XLEN:0], 1'b0};
      3'b100: begin
        addend = {m[XLEN:0], 1'b0};
        neg    = 1'b1;
      end
      3'b101, 3'b110: begin
        addend = m;
        neg    = 1'b1;
      end
      default: begin
        addend = '0;
        neg    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22041752_mul_r4.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU/MULW), 2 bits per cycle.
// Latency N+1 edges from accept (34 full, 18 word, 1 on zero operand); result held until out_ready.
module ysyx_22041752_mul_r4
  import ysyx_22041752_mul_r4_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int WORD_MODE = 1,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mul_op,
  input  logic            mul_w,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] product
);

  localparam int EW = XLEN + 2;
  localparam int AW = 2 * EW + 1;
  localparam int CW = $clog2(XLEN);
  localparam bit WORD_OK = (WORD_MODE != 0) && (XLEN == 64);
  localparam logic [CW-1:0] N_FULL = CW'((XLEN + 2) / 2);
  localparam logic [CW-1:0] N_WORD = CW'(17);

  mul_state_t    state, state_nxt;
  logic [AW-1:0] acc, acc_nxt, step;
  logic [EW-1:0] m_reg, upper, sum, addend, a_ext, b_ext, a_w, b_w;
  logic [CW-1:0] cnt;
  logic [1:0]    op_reg;
  logic          w_reg, neg, word_req, a_sgn, b_sgn, accept, early;
  logic [XLEN-1:0] res, res_w;

  assign word_req = WORD_OK && mul_w && (mul_op == MUL_OP_LO);
  assign a_sgn    = (mul_op != MUL_OP_HU);
  assign b_sgn    = (mul_op == MUL_OP_LO) || (mul_op == MUL_OP_H);

  // Word-mode operand truncation and result packing only exist for a 64-bit datapath.
  generate
    if (WORD_OK) begin : g_word
      assign a_w   = {{(EW-32){multiplicand[31]}}, multiplicand[31:0]};
      assign b_w   = {{(EW-32){multiplier[31]}}, multiplier[31:0]};
      assign res_w = {{(XLEN-32){acc_nxt[XLEN]}}, acc_nxt[XLEN-31 +: 32]};
    end else begin : g_noword
      assign a_w   = '0;
      assign b_w   = '0;
      assign res_w = '0;
    end
  endgenerate

  assign a_ext  = word_req ? a_w : {{2{a_sgn & multiplicand[XLEN-1]}}, multiplicand};
  assign b_ext  = word_req ? b_w : {{2{b_sgn & multiplier[XLEN-1]}}, multiplier};
  assign accept = in_valid && in_ready && !flush;
  assign early  = (EARLY_OUT != 0) && ((a_ext == '0) || (b_ext == '0));

  ysyx_22041752_booth_sel #(.XLEN(XLEN)) u_booth_sel (
    .sel    (acc[2:0]),
    .m      (m_reg),
    .addend (addend),
    .neg    (neg)
  );

  assign upper   = acc[AW-1 -: EW];
  assign sum     = upper + (neg ? ~addend : addend) + {{(EW-1){1'b0}}, neg};
  assign step    = {sum, acc[AW-EW-1:0]};
  assign acc_nxt = AW'($signed(step) >>> 2);

  // After the last step the full product sits at acc_nxt[2*EW:1].
  always_comb begin
    res = acc_nxt[1 +: XLEN];
    if (w_reg)                   res = res_w;
    else if (op_reg != MUL_OP_LO) res = acc_nxt[XLEN+1 +: XLEN];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      m_reg   <= '0;
      cnt     <= '0;
      op_reg  <= '0;
      w_reg   <= 1'b0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc    <= {{EW{1'b0}}, b_ext, 1'b0};
        m_reg  <= a_ext;
        op_reg <= mul_op;
        w_reg  <= word_req;
        cnt    <= word_req ? N_WORD : N_FULL;
        if (early) product <= '0;
      end else if (state == CALC && !flush) begin
        acc <= acc_nxt;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) product <= res;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = early ? DONE : CALC;
        CALC:    if (cnt == CW'(1)) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) && reset;
    out_valid = (state == DONE);
  end

endmodule

// File: tb/tb_ysyx_22041752_mul_r4.sv
// Directed bench for the radix-4 Booth multiplier: arithmetic, latency, backpressure, flush, reset.
module tb_ysyx_22041752_mul_r4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, mul_w, out_valid, out_ready;
  logic [1:0]  mul_op;
  logic [63:0] multiplicand, multiplier, product;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ysyx_22041752_mul_r4 #(.XLEN(64), .WORD_MODE(1), .EARLY_OUT(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mul_op       (mul_op),
    .mul_w        (mul_w),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic [7:0]  lat;
  } vec_t;

  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    mul_op = op; mul_w = w; multiplicand = a; multiplier = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    multiplicand = 64'hA5A5_A5A5_A5A5_A5A5;
    multiplier   = 64'h5A5A_5A5A_5A5A_5A5A;
    mul_op = 2'd1;
  endtask

  // Edges counted from the accept edge (inclusive) until out_valid is seen; bounded.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mul_op = 2'd0; mul_w = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (product !== 64'h0) begin n_fail++; $display("FAIL reset_product got %h want 0", product); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_early_backpressure();
    int lat;
    issue(2'd0, 1'b0, 64'h0, 64'hDEAD);
    wait_valid(lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL early_latency got %0d want 1", lat); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || product !== 64'h0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got vld=%b prod=%h rdy=%b want vld=1 prod=0 rdy=0", i, out_valid, product, in_ready);
      end
      @(posedge clk);
      #1;
    end
    consume();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_idle got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_arith();
    vec_t vecs[12];
    int lat;
    vecs[0]  = '{2'd0, 1'b0, 64'd3, 64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFF1, 8'd34};
    vecs[1]  = '{2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 8'd34};
    vecs[2]  = '{2'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 8'd34};
    vecs[3]  = '{2'd2, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'd34};
    vecs[4]  = '{2'd2, 1'b0, 64'd2, 64'hFFFFFFFFFFFFFFFF, 64'h1, 8'd34};
    vecs[5]  = '{2'd0, 1'b0, 64'h123456789ABCDEF0, 64'h10, 64'h23456789ABCDEF00, 8'd34};
    vecs[6]  = '{2'd3, 1'b0, 64'h8000000000000000, 64'd4, 64'h2, 8'd34};
    vecs[7]  = '{2'd1, 1'b0, 64'h8000000000000000, 64'd2, 64'hFFFFFFFFFFFFFFFF, 8'd34};
    vecs[8]  = '{2'd3, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'h1, 8'd34};
    vecs[9]  = '{2'd3, 1'b0, 64'd5, 64'd0, 64'h0, 8'd1};
    vecs[10] = '{2'd0, 1'b1, 64'hFFFFFFFF00000000, 64'd3, 64'h0, 8'd1};
    vecs[11] = '{2'd0, 1'b1, 64'h123456787FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 8'd18};
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      n_checks++;
      if (lat !== int'(vecs[i].lat)) begin n_fail++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, vecs[i].lat); end
      n_checks++;
      if (product !== vecs[i].exp) begin n_fail++; $display("FAIL vec%0d_product got %h want %h", i, product, vecs[i].exp); end
      consume();
    end
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    int lat;
    issue(2'd0, 1'b0, 64'd7, 64'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    n_checks++;
    if (product !== 64'hFFFFFFFFFFFFFFFE) begin n_fail++; $display("FAIL flush_product_kept got %h want fffffffffffffffe", product); end
    // A request arriving together with flush must not be taken.
    @(negedge clk);
    mul_op = 2'd0; mul_w = 1'b0; multiplicand = 64'd4; multiplier = 64'd4;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_no_result got seen_vld=%b rdy=%b want seen_vld=0 rdy=1", seen, in_ready);
    end
    issue(2'd0, 1'b0, 64'd2, 64'd3);
    wait_valid(lat);
    n_checks++;
    if (lat !== 34 || product !== 64'd6) begin
      n_fail++;
      $display("FAIL after_flush got lat=%0d prod=%h want lat=34 prod=6", lat, product);
    end
    // Flush wins over a simultaneous out_ready handshake.
    @(negedge clk);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0; flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 64'd6) begin
      n_fail++;
      $display("FAIL flush_done got vld=%b rdy=%b prod=%h want vld=0 rdy=1 prod=6", out_valid, in_ready, product);
    end
  endtask

  task automatic test_reset_mid();
    issue(2'd0, 1'b0, 64'd7, 64'd9);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || product !== 64'h0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_cycle%0d got vld=%b prod=%h rdy=%b want 0/0/0", i, out_valid, product, in_ready);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_early_backpressure();
    test_arith();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041752_mul_r4.md
Name: ysyx_22041752_mul_r4

Overview:
- Parametrised iterative radix-4 Booth multiplier for the EX stage; replaces the radix-2 shift-add unit.
- Handles RV64M MUL/MULH/MULHSU/MULHU plus word-mode MULW with a 32-bit sign-extended result.
- Retires 2 multiplier bits per cycle and terminates early on a zero operand.
- Uses valid/ready handshakes on both sides so the pipeline can stall the result.

Parameters:
XLEN, 64, operand/result width; even, >=8
WORD_MODE, 1, 1 = MULW supported (requires XLEN=64); 0 = mul_w ignored
EARLY_OUT, 1, 1 = zero-operand shortcut enabled

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
flush  in  1  pipeline flush; kills any in-flight operation
in_valid  in  1  request valid
in_ready  out  1  unit can accept (state IDLE and reset high)
mul_op  in  2  0=MUL(low), 1=MULH(s*s), 2=MULHSU(s*u), 3=MULHU(u*u)
mul_w  in  1  word mode; legal only with mul_op=0
multiplicand  in  XLEN  rs1
multiplier  in  XLEN  rs2
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
product  out  XLEN  result, registered

Behaviour:
- Reset (reset=0 at posedge): state=IDLE; out_valid=0; product=0; accumulator cleared. in_ready=0 while reset=0.
- States: IDLE, CALC, DONE.
- IDLE, with in_valid&in_ready&!flush:
  - Latch mode.
  - Sign- or zero-extend operands to XLEN+2 bits per mul_op; signedness: rs1 signed for MUL/MULH/MULHSU, rs2 signed for MUL/MULH.
  - Word mode: take operands[31:0] sign-extended.
  - Load acc = {0, ext(multiplier), 1'b0}; set iter count N = (XLEN+2)/2, or 17 in word mode.
  - Go to CALC.
  - EARLY_OUT and either operand (after word truncation) ==0: go directly to DONE with product=0.
- CALC, one Booth step per cycle:
  - Inspect acc[2:0].
  - Select 0/±M/±2M, where M = ext(multiplicand) at XLEN+2 bits.
  - Add to the upper part (XLEN+2 bits, carry discarded).
  - Arithmetic-shift acc right by 2.
  - Decrement count. At count==1 the step completes, product is written, and the next state is DONE.
- Latency: accept edge -> out_valid high after exactly N+1 edges: 34 for XLEN=64, 18 for MULW, 1 for early-out.
- Product select:
  - MUL: low XLEN bits.
  - MULH*: bits [2XLEN-1:XLEN] of the 2XLEN signed/unsigned product.
  - MULW: low 32 bits sign-extended to 64.
- DONE:
  - out_valid=1; product is stable until out_valid&out_ready.
  - Then IDLE with out_valid=0 on the next edge.
  - No new request is accepted in the same cycle (in_ready low in DONE).
- flush, any state: next edge -> IDLE, out_valid=0, product unchanged.
  - Flush beats a simultaneous in_valid (no accept).
  - Flush beats a simultaneous out_ready handshake (the result is discarded).
- Operands and mul_op are sampled only at accept; changes during CALC/DONE have no effect.
- mul_w with mul_op!=0, or WORD_MODE=0: mul_w is treated as 0.
- Reset mid-CALC/DONE: abort, all outputs return to their reset values.

Decomposition:
- Shared package/header: mul_op encodings (MUL_OP_LO, MUL_OP_H, MUL_OP_HSU, MUL_OP_HU) and state encoding (IDLE/CALC/DONE), added to the mycpu header alongside RF_DATA_WD.
- One sub-module, ysyx_22041752_booth_sel:
  - Combinational radix-4 partial-product selector.
  - Inputs: acc[2:0] and M. Outputs: XLEN+2-bit addend and negate flag.
  - Addition reuses the existing aser adder at width XLEN+2.

Test Plan:
- MUL, 3 * 0xFFFFFFFFFFFFFFFB (-5) -> out_valid 34 cycles after accept, product=0xFFFFFFFFFFFFFFF1.
- MULHU, 0xFFFFFFFFFFFFFFFF * 0xFFFFFFFFFFFFFFFF -> product=0xFFFFFFFFFFFFFFFE.
- MULH, -1 * -1 -> 0x0.
- MULHSU, rs1=-1, rs2=0xFFFFFFFFFFFFFFFF -> product=0xFFFFFFFFFFFFFFFF.
- MULW, rs1=0x123456787FFFFFFF, rs2=0x2 -> out_valid 18 cycles after accept, product=0xFFFFFFFFFFFFFFFE.
- Early-out and backpressure:
  - MUL 0 * 0xDEAD -> out_valid next cycle, product=0.
  - Hold out_ready=0 for 5 cycles: out_valid and product stay constant and in_ready=0.
  - out_ready=1 -> IDLE, in_ready=1 the following cycle.
- Flush and reset:
  - Issue MUL 7*9; assert flush at CALC cycle 10 -> IDLE next edge, out_valid never rises.
  - A new request 2*3 accepted afterwards yields 6.
  - Pull reset low mid-CALC -> out_valid=0, product=0, in_ready=0 until reset returns high.
